// File: rtl/gf180mcu_fd_sc_mcu9t5v0__tie_seq.sv
// Sequenced strap controller: holds N straps at TIE_VAL and releases them one bit at a time.
// Optional ACK-wait timeout with a sticky ERR output: define GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN.
module gf180mcu_fd_sc_mcu9t5v0__tie_seq #(
  parameter int            N       = 4,
  parameter int            DLY     = 8,
  parameter logic [N-1:0]  TIE_VAL = {N{1'b1}}
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
  ,
  parameter int            TO_CYC  = 255
`endif
) (
`ifdef USE_POWER_PINS
  inout  wire          VDD,
  inout  wire          VSS,
`endif
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         ABORT,
  input  logic [N-1:0] CFG,
  input  logic [N-1:0] ACK,
  output logic [N-1:0] Z,
  output logic         BUSY,
  output logic         DONE
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
  ,
  output logic         ERR
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (DLY > 1) ? $clog2(DLY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SETTLE, S_FIN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   z_q, z_d;
  logic [N-1:0]   cfg_q, cfg_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;

`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
  localparam int WW = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;
  logic           err_q, err_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      z_q     <= TIE_VAL;
      cfg_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
      err_q   <= 1'b0;
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      cfg_q   <= cfg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  // ABORT outranks START; in IDLE it has nothing to undo.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
    err_d   = err_q;
    wcnt_d  = wcnt_q;
`endif
    if (ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      z_d     = TIE_VAL;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          if (START) begin
            cfg_d   = CFG;
            z_d     = TIE_VAL;
            idx_d   = '0;
            state_d = S_APPLY;
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end
        end
        S_APPLY: begin
          z_d[idx_q] = cfg_q[idx_q];
          cnt_d      = CW'(DLY - 1);
          state_d    = S_SETTLE;
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
          wcnt_d     = '0;
`endif
        end
        S_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (ACK[idx_q]) begin
            if (idx_q == IW'(N - 1)) begin
              state_d = S_FIN;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_APPLY;
            end
          end else begin
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
            if (wcnt_q == WW'(TO_CYC - 1)) begin
              err_d   = 1'b1;
              z_d     = TIE_VAL;
              state_d = S_IDLE;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign Z    = z_q;
  assign BUSY = (state_q == S_APPLY) || (state_q == S_SETTLE);
  assign DONE = (state_q == S_FIN);
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
  assign ERR  = err_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__tie_seq.sv
// Testbench for the strap sequencer: randomized directed runs checked against a
// per-bit apply/release schedule computed arithmetically from the settle rules.
module tb_gf180mcu_fd_sc_mcu9t5v0__tie_seq;

  localparam int           N   = 4;
  localparam int           DLY = 8;
  localparam logic [N-1:0] TIE = {N{1'b1}};

  logic         CLK = 1'b0;
  logic         RST, START, ABORT;
  logic [N-1:0] CFG, ACK, Z;
  logic         BUSY, DONE;

  logic         start1, abort1;
  logic [0:0]   cfg1, ack1, z1;
  logic         busy1, done1;

`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
  logic         ERR, err1;
`endif
`ifdef USE_POWER_PINS
  wire vdd = 1'b1;
  wire vss = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__tie_seq #(.N(N), .DLY(DLY), .TIE_VAL(TIE)) u_dut (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .CFG(CFG), .ACK(ACK),
    .Z(Z), .BUSY(BUSY), .DONE(DONE)
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
    , .ERR(ERR)
`endif
  );

  gf180mcu_fd_sc_mcu9t5v0__tie_seq #(.N(1), .DLY(1), .TIE_VAL(1'b1)) u_dut1 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(CLK), .RST(RST), .START(start1), .ABORT(abort1), .CFG(cfg1), .ACK(ack1),
    .Z(z1), .BUSY(busy1), .DONE(done1)
`ifdef GF180MCU_FD_SC_MCU9T5V0__TIE_SEQ_TIMEOUT_EN
    , .ERR(err1)
`endif
  );

  task automatic checkOutput(input string tag, input logic [15:0] obsZ, input logic [15:0] expZ,
                             input logic obsB, input logic expB, input logic obsD, input logic expD);
    total++;
    assert (obsZ === expZ) else begin
      bad++;
      $error("FAIL %s Z observed=%h expected=%h", tag, obsZ, expZ);
    end
    total++;
    assert (obsB === expB) else begin
      bad++;
      $error("FAIL %s BUSY observed=%b expected=%b", tag, obsB, expB);
    end
    total++;
    assert (obsD === expD) else begin
      bad++;
      $error("FAIL %s DONE observed=%b expected=%b", tag, obsD, expD);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic rs,
                               input logic [N-1:0] cfg, input logic [N-1:0] ack);
    START = st;
    ABORT = ab;
    RST   = rs;
    CFG   = cfg;
    ACK   = ack;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Edge 0 is the START edge. Bit b is applied at edge a[b] and released at
  // l[b], the first edge at least DLY after a[b] where its ACK is sampled high.
  task automatic runSeq(input string name, input logic [N-1:0] cfg,
                        input int abortAt, input int rstAt, input logic stall);
    int           ackUntil[N];
    int           a[N];
    int           l[N];
    int           finEdge;
    logic [N-1:0] expZ;
    logic [N-1:0] ackv;
    logic         st;
    for (int b = 0; b < N; b++) begin
      a[b] = (b == 0) ? 1 : l[b-1] + 1;
      if (stall && ($urandom_range(0, 1) == 1))
        ackUntil[b] = a[b] + DLY + int'($urandom_range(1, 12));
      else
        ackUntil[b] = int'($urandom_range(0, a[b] + DLY));
      l[b] = (ackUntil[b] > a[b] + DLY) ? ackUntil[b] : a[b] + DLY;
    end
    finEdge = l[N-1];
    for (int b = 0; b < N; b++) ackv[b] = (0 >= ackUntil[b]);
    applyStimulus(1'b1, 1'b0, 1'b0, cfg, ackv);
    for (int e = 0; e <= finEdge + 2; e++) begin
      tick();
      if ((e == abortAt) || (e == rstAt)) begin
        checkOutput($sformatf("%s stop e%0d", name, e), 16'(Z), 16'(TIE), BUSY, 1'b0, DONE, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, N'($urandom), {N{1'b1}});
        return;
      end
      expZ = TIE;
      for (int b = 0; b < N; b++) if (a[b] <= e) expZ[b] = cfg[b];
      checkOutput($sformatf("%s e%0d", name, e), 16'(Z), 16'(expZ), BUSY, (e < finEdge), DONE, (e >= finEdge));
      for (int b = 0; b < N; b++) ackv[b] = (e + 1 >= ackUntil[b]);
      st = (e < finEdge) && ($urandom_range(0, 3) == 0);
      applyStimulus(st, (e + 1 == abortAt), (e + 1 == rstAt), N'($urandom), ackv);
    end
  endtask

  initial begin
    start1 = 1'b0;
    abort1 = 1'b0;
    cfg1   = 1'b0;
    ack1   = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    tick();
    checkOutput("reset", 16'(Z), 16'(TIE), BUSY, 1'b0, DONE, 1'b0);
    checkOutput("reset1", 16'(z1), 16'h0001, busy1, 1'b0, done1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '1);
    tick();
    checkOutput("idle", 16'(Z), 16'(TIE), BUSY, 1'b0, DONE, 1'b0);

    runSeq("basic", 4'b0101, -1, -1, 1'b0);
    runSeq("stall0", 4'b0000, -1, -1, 1'b1);
    for (int i = 0; i < 3; i++) runSeq($sformatf("rand%0d", i), N'($urandom), -1, -1, 1'b1);
    runSeq("abort", 4'b0101, 15, -1, 1'b0);
    tick();
    checkOutput("abort idle", 16'(Z), 16'(TIE), BUSY, 1'b0, DONE, 1'b0);
    runSeq("rst", N'($urandom), -1, 20, 1'b1);
    runSeq("finabort", 4'b0011, -1, -1, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, '1);
    tick();
    checkOutput("start+abort", 16'(Z), 16'(TIE), BUSY, 1'b0, DONE, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, '1);
    tick();
    checkOutput("abort in idle", 16'(Z), 16'(TIE), BUSY, 1'b0, DONE, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, '1);

    // Single-strap instance with DLY=1: two edges per bit.
    start1 = 1'b1;
    cfg1   = 1'b0;
    tick();
    checkOutput("n1 e0", 16'(z1), 16'h0001, busy1, 1'b1, done1, 1'b0);
    start1 = 1'b0;
    cfg1   = 1'b1;
    tick();
    checkOutput("n1 e1", 16'(z1), 16'h0000, busy1, 1'b1, done1, 1'b0);
    tick();
    checkOutput("n1 e2", 16'(z1), 16'h0000, busy1, 1'b0, done1, 1'b1);
    tick();
    checkOutput("n1 hold", 16'(z1), 16'h0000, busy1, 1'b0, done1, 1'b1);
    start1 = 1'b1;
    cfg1   = 1'b1;
    tick();
    checkOutput("n1 restart", 16'(z1), 16'h0001, busy1, 1'b1, done1, 1'b0);
    start1 = 1'b0;
    cfg1   = 1'b0;
    tick();
    checkOutput("n1 re e1", 16'(z1), 16'h0001, busy1, 1'b1, done1, 1'b0);
    tick();
    checkOutput("n1 re e2", 16'(z1), 16'h0001, busy1, 1'b0, done1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
